// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg
//   Shared constants and types for the fetch-PC controller slice.
//   XLEN / INSTR_BYTES : datapath width and instruction size in bytes.
//   FLUSH_CNT_W        : width of the flush duration counter (1..15 cycles).
//   ALIGN_MASK         : clears the byte-offset bits of an instruction address.
//   fetch_state_t      : controller states BOOT, RUN, FLUSH.
package pc_fetch_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned INSTR_BYTES = 4;
   localparam int unsigned FLUSH_CNT_W = 4;

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch_ctrl_timer.sv
// pc_flush_timer
//   Loadable down-counter timing the flush window after a redirect.
//   clk, rst  : clock, synchronous active-high reset (count clears to 0)
//   load      : load loadValue (priority over decrement)
//   loadValue : flush duration in cycles
//   busy      : count is non-zero
//   done      : count is 1, i.e. this is the last flush cycle
module pc_flush_timer
   import pc_fetch_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [FLUSH_CNT_W-1:0] loadValue,
   output logic                   busy,
   output logic                   done
);

   logic [FLUSH_CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= loadValue;
      end else if (busy) begin
         count <= count - 1'b1;
      end
   end

   assign busy = (count != '0);
   assign done = (count == FLUSH_CNT_W'(1));

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Owns the architectural fetch PC, issues sequential fetch requests over a
//   valid/ready handshake and redirects on a taken branch, holding flush high
//   for FLUSH_CYCLES cycles afterwards.
//   Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned target traps to
//   TRAP_VEC and pulses misalign; otherwise target low bits are cleared).
//   clk, rst                 : clock, synchronous active-high reset
//   takeBranch, branchTarget : redirect request and address from BranchUnit
//   stall                    : hazard hold, blocks sequential advance
//   fetchReady               : instruction memory accepts the request
//   fetchValid, fetchAddr    : registered fetch request
//   pcPlus4                  : fetchAddr + 4 (combinational)
//   flush                    : registered kill of IF/ID
//   misalign                 : registered trap pulse (macro builds only)
module pc_fetch_ctrl
   import pc_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned FLUSH_CYCLES = 2
`ifdef PC_MISALIGN_TRAP_EN
   ,parameter logic [31:0] TRAP_VEC    = 32'h0000_0100
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        takeBranch,
   input  logic [31:0] branchTarget,
   input  logic        stall,
   input  logic        fetchReady,
   output logic        fetchValid,
   output logic [31:0] fetchAddr,
   output logic [31:0] pcPlus4,
   output logic        flush
`ifdef PC_MISALIGN_TRAP_EN
   ,output logic       misalign
`endif
);

   fetch_state_t    state, stateNext;
   logic [XLEN-1:0] addrNext;
   logic [XLEN-1:0] redirectAddr;
   logic            accept;
   logic            timerLoad;
   logic            timerBusy;
   logic            timerDone;

   assign accept  = fetchValid & fetchReady;
   assign pcPlus4 = fetchAddr + XLEN'(INSTR_BYTES);

`ifdef PC_MISALIGN_TRAP_EN
   logic badTarget;
   assign badTarget    = (branchTarget[1:0] != 2'b00);
   assign redirectAddr = badTarget ? (TRAP_VEC & ALIGN_MASK)
                                   : (branchTarget & ALIGN_MASK);
`else
   assign redirectAddr = branchTarget & ALIGN_MASK;
`endif

   // Redirect outranks stall and any same-cycle accept: the pending request
   // is dropped and the PC jumps straight to the target.
   always_comb begin
      stateNext = state;
      addrNext  = fetchAddr;
      timerLoad = 1'b0;
      if (takeBranch) begin
         stateNext = FLUSH;
         addrNext  = redirectAddr;
         timerLoad = 1'b1;
      end else begin
         case (state)
            BOOT:    stateNext = RUN;
            RUN:     if (accept && !stall) addrNext = pcPlus4;
            // Exit also on an idle timer so the FSM can never wedge in FLUSH.
            FLUSH:   if (timerDone || !timerBusy) stateNext = RUN;
            default: stateNext = BOOT;
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= BOOT;
         fetchAddr  <= RESET_PC;
         fetchValid <= 1'b0;
         flush      <= 1'b0;
      end else begin
         state      <= stateNext;
         fetchAddr  <= addrNext;
         fetchValid <= (stateNext == RUN);
         flush      <= (stateNext == FLUSH);
      end
   end

`ifdef PC_MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         misalign <= 1'b0;
      end else begin
         misalign <= takeBranch & badTarget;
      end
   end
`endif

   pc_flush_timer uFlushTimer (
      .clk       (clk),
      .rst       (rst),
      .load      (timerLoad),
      .loadValue (FLUSH_CNT_W'(FLUSH_CYCLES)),
      .busy      (timerBusy),
      .done      (timerDone)
   );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl
//   Directed bench for pc_fetch_ctrl: a cycle-level reference model checked
//   every cycle plus literal expectations at key points of the sequence.
//   Honours PC_MISALIGN_TRAP_EN (trap build uses TRAP_VEC = 32'h300).
module tb_pc_fetch_ctrl;

   localparam logic [31:0] RST_PC  = 32'h0000_0000;
   localparam int unsigned FLUSH_N = 2;
   localparam logic [31:0] TRAP_PC = 32'h0000_0300;

   logic        clk = 1'b0;
   logic        rst;
   logic        takeBranch;
   logic [31:0] branchTarget;
   logic        stall;
   logic        fetchReady;
   logic        fetchValid;
   logic [31:0] fetchAddr;
   logic [31:0] pcPlus4;
   logic        flush;
`ifdef PC_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_fetch_ctrl #(
      .RESET_PC     (RST_PC),
      .FLUSH_CYCLES (FLUSH_N)
`ifdef PC_MISALIGN_TRAP_EN
      ,.TRAP_VEC    (TRAP_PC)
`endif
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .takeBranch   (takeBranch),
      .branchTarget (branchTarget),
      .stall        (stall),
      .fetchReady   (fetchReady),
      .fetchValid   (fetchValid),
      .fetchAddr    (fetchAddr),
      .pcPlus4      (pcPlus4),
      .flush        (flush)
`ifdef PC_MISALIGN_TRAP_EN
      ,.misalign    (misalign)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: PC, request-valid flag and remaining flush cycles.
   logic [31:0] mAddr;
   logic        mValid;
   int          mFlushLeft;
   logic        mMis;
   logic        mBad;

   always begin
      @(posedge clk);
      if (rst) begin
         mAddr      = RST_PC;
         mValid     = 1'b0;
         mFlushLeft = 0;
         mMis       = 1'b0;
      end else if (takeBranch) begin
         mBad  = (branchTarget[1:0] != 2'b00);
         mAddr = {branchTarget[31:2], 2'b00};
`ifdef PC_MISALIGN_TRAP_EN
         if (mBad) mAddr = TRAP_PC;
         mMis = mBad;
`else
         mMis = 1'b0;
`endif
         mFlushLeft = FLUSH_N;
         mValid     = 1'b0;
      end else begin
         mMis = 1'b0;
         if (mFlushLeft > 0) begin
            mFlushLeft--;
            mValid = (mFlushLeft == 0);
         end else begin
            if (mValid && fetchReady && !stall) mAddr = mAddr + 32'd4;
            mValid = 1'b1;
         end
      end
      #1;
      chk("model fetchAddr",  fetchAddr,  mAddr);
      chk("model fetchValid", {31'b0, fetchValid}, {31'b0, mValid});
      chk("model flush",      {31'b0, flush}, {31'b0, (mFlushLeft > 0)});
      chk("model pcPlus4",    pcPlus4,    mAddr + 32'd4);
`ifdef PC_MISALIGN_TRAP_EN
      chk("model misalign",   {31'b0, misalign}, {31'b0, mMis});
`endif
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic expect3(input string tag, input logic v, input logic f, input logic [31:0] a);
      chk({tag, " valid"}, {31'b0, fetchValid}, {31'b0, v});
      chk({tag, " flush"}, {31'b0, flush}, {31'b0, f});
      chk({tag, " addr"},  fetchAddr, a);
   endtask

   logic [31:0] misTarget;

   initial begin
      rst = 1'b1; takeBranch = 1'b0; branchTarget = '0; stall = 1'b0; fetchReady = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misTarget = TRAP_PC;
`else
      misTarget = 32'h0000_0100;
`endif
      cyc(); cyc();
      expect3("reset", 1'b0, 1'b0, 32'h0);
      chk("reset pcPlus4", pcPlus4, 32'h4);

      rst = 1'b0; fetchReady = 1'b1;
      cyc(); expect3("boot", 1'b1, 1'b0, 32'h0);
      cyc(); expect3("seq1", 1'b1, 1'b0, 32'h4);
      cyc(); expect3("seq2", 1'b1, 1'b0, 32'h8);
      fetchReady = 1'b0;
      cyc(); expect3("noready1", 1'b1, 1'b0, 32'h8);
      cyc(); expect3("noready2", 1'b1, 1'b0, 32'h8);
      stall = 1'b1; fetchReady = 1'b1;
      cyc(); expect3("stall", 1'b1, 1'b0, 32'h8);

      takeBranch = 1'b1; branchTarget = 32'h100;
      cyc(); expect3("br1 f1", 1'b0, 1'b1, 32'h100);
      takeBranch = 1'b0; stall = 1'b0;
      cyc(); expect3("br1 f2", 1'b0, 1'b1, 32'h100);
      cyc(); expect3("br1 run", 1'b1, 1'b0, 32'h100);
      cyc(); expect3("br1 seq", 1'b1, 1'b0, 32'h104);

      takeBranch = 1'b1; branchTarget = 32'h180;
      cyc(); expect3("br2 f1", 1'b0, 1'b1, 32'h180);
      branchTarget = 32'h200;
      cyc(); expect3("br3 f1", 1'b0, 1'b1, 32'h200);
      takeBranch = 1'b0;
      cyc(); expect3("br3 f2", 1'b0, 1'b1, 32'h200);
      cyc(); expect3("br3 run", 1'b1, 1'b0, 32'h200);

      takeBranch = 1'b1; branchTarget = 32'hFFFF_FFFC;
      cyc(); takeBranch = 1'b0;
      cyc();
      cyc(); expect3("wrap at", 1'b1, 1'b0, 32'hFFFF_FFFC);
      chk("wrap pcPlus4", pcPlus4, 32'h0);
      cyc(); expect3("wrap next", 1'b1, 1'b0, 32'h0);

      takeBranch = 1'b1; branchTarget = 32'h102;
      cyc(); expect3("mis f1", 1'b0, 1'b1, misTarget);
`ifdef PC_MISALIGN_TRAP_EN
      chk("mis pulse", {31'b0, misalign}, 32'h1);
`endif
      takeBranch = 1'b0;
      cyc(); expect3("mis f2", 1'b0, 1'b1, misTarget);
`ifdef PC_MISALIGN_TRAP_EN
      chk("mis pulse end", {31'b0, misalign}, 32'h0);
`endif
      cyc(); expect3("mis run", 1'b1, 1'b0, misTarget);

      rst = 1'b1; takeBranch = 1'b1; branchTarget = 32'h400;
      cyc(); expect3("rst+br", 1'b0, 1'b0, RST_PC);
      rst = 1'b0; takeBranch = 1'b0; fetchReady = 1'b0;
      cyc(); expect3("rst release", 1'b1, 1'b0, RST_PC);
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
